digit_emitter: RTL and testbench

//  Converts a binary value back into decimal keypad-style digits, the inverse of the digit accumulator.

---
 rtl/digit_pkg.sv | 18 +
 rtl/bcd_adjust_shift.sv | 25 ++
 rtl/digit_emitter.sv | 125 ++++++++++++
 tb/tb_digit_emitter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the decimal digit path (emitter and accumulator).
package digit_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift
  localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    PREP,
    EMIT
  } emit_state_t;

endpackage

// File: rtl/bcd_adjust_shift.sv
// One double-dabble step: add-3 correction on every BCD nibble, then shift in the binary MSB.
module bcd_adjust_shift
  import digit_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*DIGIT_W-1:0] bcd_i,
  input  logic                      bin_msb_i,
  output logic [DIGITS*DIGIT_W-1:0] bcd_o
);

  localparam int BCD_W = DIGITS * DIGIT_W;

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[i*DIGIT_W +: DIGIT_W] >= ADJ_THRESH)
        adj[i*DIGIT_W +: DIGIT_W] = bcd_i[i*DIGIT_W +: DIGIT_W] + ADJ_ADD;
    end
    bcd_o = (adj << 1) | BCD_W'(bin_msb_i);
  end

endmodule

// File: rtl/digit_emitter.sv
// Binary-to-decimal digit emitter: double-dabble conversion, then one digit per
// valid/ready transfer, most significant first.
module digit_emitter
  import digit_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DIGITS         = 5,
  parameter int SUPPRESS_ZEROS = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  output logic               busy,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  input  logic               digit_ready,
  output logic               digit_last
);

  localparam int BCD_W = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  emit_state_t        state_q;
  logic [WIDTH-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_dn;
  logic [IDX_W-1:0]   msd_idx;
  logic               busy_q;
  logic [DIGIT_W-1:0] digit_q;
  logic               valid_q;
  logic               last_q;

  function automatic logic [DIGIT_W-1:0] digit_at(input logic [BCD_W-1:0] bcd,
                                                  input logic [IDX_W-1:0] i);
    return bcd[i*DIGIT_W +: DIGIT_W];
  endfunction

  bcd_adjust_shift #(.DIGITS(DIGITS)) u_step (
    .bcd_i     (bcd_q),
    .bin_msb_i (bin_q[WIDTH-1]),
    .bcd_o     (bcd_d)
  );

  assign idx_dn = idx_q - 1'b1;

  // Start index: the leading non-zero digit, or the full width when zeros are kept
  always_comb begin
    msd_idx = '0;
    if (SUPPRESS_ZEROS == 0) begin
      msd_idx = IDX_W'(DIGITS - 1);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bcd_q[i*DIGIT_W +: DIGIT_W] != '0) msd_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      digit_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= PREP;
        end
        PREP: begin
          idx_q   <= msd_idx;
          state_q <= EMIT;
        end
        EMIT: begin
          // First EMIT cycle only loads the output register; later cycles advance on transfer
          if (!valid_q) begin
            digit_q <= digit_at(bcd_q, idx_q);
            valid_q <= 1'b1;
            last_q  <= (idx_q == '0);
          end else if (digit_ready) begin
            if (last_q) begin
              digit_q <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_dn;
              digit_q <= digit_at(bcd_q, idx_dn);
              last_q  <= (idx_q == IDX_W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign digit       = digit_q;
  assign digit_valid = valid_q;
  assign digit_last  = last_q;

endmodule

// File: tb/tb_digit_emitter.sv
// Directed bench for digit_emitter: a zero-suppressing instance and a fixed-width instance.
module tb_digit_emitter;

  logic        clock;
  logic        reset;
  logic        start_a, start_b;
  logic [15:0] value;
  logic        ready;

  logic       a_busy, a_valid, a_last;
  logic [3:0] a_digit;
  logic       b_busy, b_valid, b_last;
  logic [3:0] b_digit;

  int total = 0;
  int bad   = 0;

  digit_emitter #(.WIDTH(16), .DIGITS(5), .SUPPRESS_ZEROS(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .value(value),
    .busy(a_busy), .digit(a_digit), .digit_valid(a_valid),
    .digit_ready(ready), .digit_last(a_last)
  );

  digit_emitter #(.WIDTH(16), .DIGITS(5), .SUPPRESS_ZEROS(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .value(value),
    .busy(b_busy), .digit(b_digit), .digit_valid(b_valid),
    .digit_ready(ready), .digit_last(b_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int g_valid(input bit sz);
    return sz ? int'(a_valid) : int'(b_valid);
  endfunction
  function automatic int g_busy(input bit sz);
    return sz ? int'(a_busy) : int'(b_busy);
  endfunction
  function automatic int g_digit(input bit sz);
    return sz ? int'(a_digit) : int'(b_digit);
  endfunction
  function automatic int g_last(input bit sz);
    return sz ? int'(a_last) : int'(b_last);
  endfunction

  // Start a conversion and collect every digit, checking order, last flag, latency and loopback sum
  task automatic run_num(input bit sz, input logic [15:0] v, input string exp,
                         input int stall, input bit inject, input string tag);
    int lat;
    int acc;
    int held;
    int n;
    n = exp.len();
    acc = 0;
    @(negedge clock);
    value = v;
    if (sz) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
    check({tag, "_busy"}, g_busy(sz), 1);
    lat = 0;
    while (g_valid(sz) == 0 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 18);
    if (g_valid(sz) == 0) return;
    for (int i = 0; i < n; i++) begin
      check({tag, "_digit"}, g_digit(sz), int'(exp[i]) - 48);
      check({tag, "_last"}, g_last(sz), (i == n - 1) ? 1 : 0);
      if (stall > 0) begin
        ready = 1'b0;
        held = g_digit(sz);
        for (int s = 0; s < stall; s++) begin
          @(posedge clock); #1;
          check({tag, "_hold"}, (g_valid(sz) == 1 && g_digit(sz) == held) ? 1 : 0, 1);
        end
        ready = 1'b1;
      end
      if (inject && i == 1) begin
        value = 16'd1;
        if (sz) start_a = 1'b1; else start_b = 1'b1;
      end
      acc = acc * 10 + g_digit(sz);
      @(posedge clock); #1;
      start_a = 1'b0; start_b = 1'b0;
    end
    check({tag, "_valid_drop"}, g_valid(sz), 0);
    check({tag, "_busy_drop"}, g_busy(sz), 0);
    check({tag, "_loopback"}, acc, int'(v));
    if (inject) begin
      repeat (3) @(posedge clock);
      #1;
      check({tag, "_no_recapture"}, g_busy(sz), 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    value = '0;
    ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_valid", a_valid, 0);
    check("rst_digit", a_digit, 0);
    check("rst_last", a_last, 0);
    @(negedge clock);
    reset = 1'b0;

    run_num(1'b1, 16'd4632,  "4632",  0, 1'b0, "v4632");
    run_num(1'b1, 16'd0,     "0",     0, 1'b0, "v0");
    run_num(1'b1, 16'd65535, "65535", 0, 1'b0, "vmax");
    run_num(1'b1, 16'd10,    "10",    0, 1'b0, "v10");
    run_num(1'b1, 16'd7,     "7",     0, 1'b0, "v7");
    run_num(1'b1, 16'd1234,  "1234",  0, 1'b0, "v1234");
    run_num(1'b1, 16'd907,   "907",   5, 1'b0, "v907_stall");
    run_num(1'b1, 16'd4632,  "4632",  0, 1'b1, "v4632_inject");
    run_num(1'b0, 16'd0,     "00000", 0, 1'b0, "nz_v0");
    run_num(1'b0, 16'd305,   "00305", 0, 1'b0, "nz_v305");

    // Reset in the middle of conversion
    @(negedge clock);
    value = 16'd4632;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_conv_busy", a_busy, 0);
    check("rst_conv_valid", a_valid, 0);
    @(negedge clock);
    reset = 1'b0;

    // Reset while a digit is being held by backpressure
    @(negedge clock);
    value = 16'd4632;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    ready = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("pre_rst_emit_valid", a_valid, 1);
    check("pre_rst_emit_digit", a_digit, 4);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_emit_valid", a_valid, 0);
    check("rst_emit_digit", a_digit, 0);
    check("rst_emit_last", a_last, 0);
    check("rst_emit_busy", a_busy, 0);
    @(negedge clock);
    reset = 1'b0;
    ready = 1'b1;

    run_num(1'b1, 16'd123, "123", 0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
